// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority voting at bit centre,
// optional parity, 1-2 stop bits, valid/ready output holding register with overrun and break pulses.
module uart_rx_cfg #(
    parameter int BAUD_DIV  = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       brk
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int HALF  = BAUD_DIV / 2;
    localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           state, state_d;
    logic [1:0]       sync;
    logic             rxs;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             samp_a, samp_b, bit_val;
    logic             at_sample, bit_end, frame_done;
    logic [7:0]       shreg;
    logic             par_acc, perr_acc, ferr_acc, seen_one, brk_hold;
    logic             is_break, ferr_final;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], rx};
    end
    assign rxs = sync[1];

    assign at_sample = (cnt == SAMP_C);
    assign bit_end   = (cnt == BIT_LAST);
    assign bit_val   = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_d    = state;
        frame_done = 1'b0;
        unique case (state)
            S_IDLE:   if (!brk_hold && !rxs) state_d = S_START;
            S_START: begin
                if (at_sample && bit_val) state_d = S_IDLE;
                else if (bit_end)         state_d = S_DATA;
            end
            S_DATA:   if (bit_end && bit_idx == DATA_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP: begin
                if (at_sample && bit_idx == STOP_LAST) begin
                    state_d    = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Bit-relative counter restarts every bit; bit_idx restarts on each state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
        end else begin
            if (cnt == SAMP_A) samp_a <= rxs;
            if (cnt == SAMP_B) samp_b <= rxs;
            if (state == S_IDLE) begin
                cnt     <= '0;
                bit_idx <= '0;
            end else if (bit_end) begin
                cnt     <= '0;
                bit_idx <= (state_d != state) ? 3'd0 : bit_idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            par_acc  <= 1'b0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            seen_one <= 1'b0;
        end else if (state == S_IDLE) begin
            shreg    <= '0;
            par_acc  <= 1'b0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            seen_one <= 1'b0;
        end else if (at_sample) begin
            unique case (state)
                S_DATA: begin
                    shreg[bit_idx] <= bit_val;
                    par_acc        <= par_acc ^ bit_val;
                    seen_one       <= seen_one | bit_val;
                end
                S_PARITY: begin
                    perr_acc <= par_acc ^ bit_val ^ ODD_PAR;
                    seen_one <= seen_one | bit_val;
                end
                S_STOP: begin
                    ferr_acc <= ferr_acc | ~bit_val;
                    seen_one <= seen_one | bit_val;
                end
                default: ;
            endcase
        end
    end

    // The last stop sample is folded in combinationally so results land the cycle after it.
    assign is_break   = ~(seen_one | bit_val);
    assign ferr_final = ferr_acc | ~bit_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            brk        <= 1'b0;
            brk_hold   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            brk     <= 1'b0;
            if (valid && ready) valid <= 1'b0;
            if (brk_hold && rxs) brk_hold <= 1'b0;
            if (frame_done) begin
                if (is_break) begin
                    brk      <= 1'b1;
                    brk_hold <= 1'b1;
                end else if (!valid || ready) begin
                    data_out   <= shreg;
                    parity_err <= perr_acc;
                    frame_err  <= ferr_final;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
